// File: rtl/display_mode_ctrl.sv
// Front-panel 7-seg source sequencer: switch sync/debounce, optional auto-rotation,
// and a fixed blanking interval around every source change.
module display_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLANK_CYCLES    = 50_000,
    parameter int DWELL_CYCLES    = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_left,
    input  logic       sw_right,
    input  logic       auto_en,
    output logic [1:0] mode,
    output logic       blank,
    output logic       mode_strobe
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    logic [1:0]         s1_q, s2_q, s2d_q;
    logic [1:0]         deb_q, deb_d;
    logic [DEB_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         rot_q, rot_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [0:0]         state_q, state_d;
    logic [1:0]         target_q, target_d;
    logic [BLANK_W-1:0] bcnt_q, bcnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               blank_q, blank_d;
    logic               strobe_q, strobe_d;
    logic [1:0]         req;
    logic               rotating;

    assign rotating = auto_en && (deb_q == 2'b00);
    assign req      = rotating ? rot_q : deb_q;

    // deb only adopts a code that stayed unchanged for DEBOUNCE_CYCLES; any bounce restarts.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        deb_d = deb_q;
        cnt_d = cnt_q;
        if ((s2_q != s2d_q) || (s2_q == deb_q)) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DEB_W'(1);
        end
    end

    // Rotation pauses while a change is being blanked so the pending target stays requested.
    always_comb begin
        rot_d  = rot_q;
        dcnt_d = dcnt_q;
        if (!rotating) begin
            rot_d  = 2'b00;
            dcnt_d = '0;
        end else if (state_q == ST_SHOW) begin
            if (dcnt_q == DWELL_LAST) begin
                dcnt_d = '0;
                rot_d  = (rot_q == 2'b10) ? 2'b00 : rot_q + 2'b01;
            end else begin
                dcnt_d = dcnt_q + DWELL_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        bcnt_d   = bcnt_q;
        mode_d   = mode_q;
        blank_d  = blank_q;
        strobe_d = 1'b0;
        case (state_q)
            ST_SHOW: begin
                blank_d = (mode_q == 2'b11);
                if (req != mode_q) begin
                    target_d = req;
                    bcnt_d   = '0;
                    blank_d  = 1'b1;
                    state_d  = ST_BLANK;
                end
            end
            ST_BLANK: begin
                blank_d = 1'b1;
                if (req != target_q) begin
                    target_d = req;
                    bcnt_d   = '0;
                end else if (bcnt_q == BLANK_LAST) begin
                    mode_d   = target_q;
                    strobe_d = 1'b1;
                    blank_d  = (target_q == 2'b11);
                    state_d  = ST_SHOW;
                end else begin
                    bcnt_d = bcnt_q + BLANK_W'(1);
                end
            end
            default: state_d = ST_SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            s1_q     <= 2'b00;
            s2_q     <= 2'b00;
            s2d_q    <= 2'b00;
            deb_q    <= 2'b00;
            cnt_q    <= '0;
            rot_q    <= 2'b00;
            dcnt_q   <= '0;
            state_q  <= ST_SHOW;
            target_q <= 2'b00;
            bcnt_q   <= '0;
            mode_q   <= 2'b00;
            blank_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            s1_q     <= {sw_left, sw_right};
            s2_q     <= s1_q;
            s2d_q    <= s2_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            rot_q    <= rot_d;
            dcnt_q   <= dcnt_d;
            state_q  <= state_d;
            target_q <= target_d;
            bcnt_q   <= bcnt_d;
            mode_q   <= mode_d;
            blank_q  <= blank_d;
            strobe_q <= strobe_d;
        end
    end

    assign mode        = mode_q;
    assign blank       = blank_q;
    assign mode_strobe = strobe_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl with short debounce/blank/dwell intervals.
// Cycle counts are edges after the switch change is driven: 2 sync + 1 s2d + 4 debounce + 1 enter BLANK.
module tb_display_mode_ctrl;

    localparam int DEB   = 4;
    localparam int BLK   = 3;
    localparam int DWELL = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_left = 1'b0;
    logic       sw_right = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] mode;
    logic       blank;
    logic       mode_strobe;

    display_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLANK_CYCLES   (BLK),
        .DWELL_CYCLES   (DWELL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_left    (sw_left),
        .sw_right   (sw_right),
        .auto_en    (auto_en),
        .mode       (mode),
        .blank      (blank),
        .mode_strobe(mode_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [1:0] sw;
        logic       auto_en;
        int         n;
        logic [1:0] mode;
        logic       blank;
        logic       strobe;
    } vec_t;

    typedef struct {
        logic [1:0] mode;
        logic       blank;
        logic       strobe;
    } exp_t;

    vec_t       tbl[$];
    exp_t       sb[$];
    logic [1:0] sb_mode[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] s, input logic a, input int n,
                       input logic [1:0] m, input logic b, input logic st);
        vec_t v;
        v.rst_n = r; v.sw = s; v.auto_en = a; v.n = n;
        v.mode = m; v.blank = b; v.strobe = st;
        tbl.push_back(v);
    endtask

    // Drive on the falling edge, advance past the next rising edge, sample 1 time unit later.
    task automatic tick(input logic r, input logic [1:0] s, input logic a);
        @(negedge clk);
        rst_n    = r;
        sw_left  = s[1];
        sw_right = s[0];
        auto_en  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic r, input logic [1:0] s, input logic a,
                        input logic [1:0] m, input logic b, input logic st);
        exp_t e;
        e.mode = m; e.blank = b; e.strobe = st;
        sb.push_back(e);
        tick(r, s, a);
        e = sb.pop_front();
        check(name, int'({mode, blank, mode_strobe}), int'({e.mode, e.blank, e.strobe}));
    endtask

    initial begin
        int         blank_run;
        int         first_strobe;
        logic       saw11;
        logic [1:0] want;

        // Reset and idle at 00.
        add(0, 2'b00, 0, 2,  2'b00, 0, 0);
        add(1, 2'b00, 0, 10, 2'b00, 0, 0);
        // Clean 00->10: blank on edge 8 for 3 cycles, commit with strobe on edge 11.
        add(1, 2'b10, 0, 7,  2'b00, 0, 0);
        add(1, 2'b10, 0, 3,  2'b00, 1, 0);
        add(1, 2'b10, 0, 1,  2'b10, 0, 1);
        add(1, 2'b10, 0, 4,  2'b10, 0, 0);
        // Reset in the middle of a 00->10 blank, then the change replays from scratch.
        add(0, 2'b00, 0, 2,  2'b00, 0, 0);
        add(1, 2'b10, 0, 7,  2'b00, 0, 0);
        add(1, 2'b10, 0, 1,  2'b00, 1, 0);
        add(0, 2'b10, 0, 1,  2'b00, 0, 0);
        add(1, 2'b10, 0, 7,  2'b00, 0, 0);
        add(1, 2'b10, 0, 3,  2'b00, 1, 0);
        add(1, 2'b10, 0, 1,  2'b10, 0, 1);
        add(1, 2'b10, 0, 3,  2'b10, 0, 0);
        // 10->01, then 01->11 where blank stays high after the commit.
        add(1, 2'b01, 0, 7,  2'b10, 0, 0);
        add(1, 2'b01, 0, 3,  2'b10, 1, 0);
        add(1, 2'b01, 0, 1,  2'b01, 0, 1);
        add(1, 2'b01, 0, 3,  2'b01, 0, 0);
        add(1, 2'b11, 0, 7,  2'b01, 0, 0);
        add(1, 2'b11, 0, 3,  2'b01, 1, 0);
        add(1, 2'b11, 0, 1,  2'b11, 1, 1);
        add(1, 2'b11, 0, 5,  2'b11, 1, 0);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                step($sformatf("vec%0d.%0d", i, k), tbl[i].rst_n, tbl[i].sw, tbl[i].auto_en,
                     tbl[i].mode, tbl[i].blank, tbl[i].strobe);
            end
        end

        // Bouncing switch: runs of 2 never reach the debounce count.
        for (int k = 0; k < 2; k++) step("bounce_rst", 0, 2'b00, 0, 2'b00, 0, 0);
        for (int k = 0; k < 3; k++) step("bounce_idle", 1, 2'b00, 0, 2'b00, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step("bounce_01", 1, 2'b01, 0, 2'b00, 0, 0);
            step("bounce_01", 1, 2'b01, 0, 2'b00, 0, 0);
            step("bounce_00", 1, 2'b00, 0, 2'b00, 0, 0);
            step("bounce_00", 1, 2'b00, 0, 2'b00, 0, 0);
        end
        for (int k = 0; k < 8; k++) step("bounce_settle", 1, 2'b00, 0, 2'b00, 0, 0);

        // Request changes during BLANK: rotation asks for 01, auto_en drops on the 2nd
        // blank cycle so the request returns to 00; interval restarts and still strobes.
        for (int k = 0; k < 2; k++) step("restart_rst", 0, 2'b00, 0, 2'b00, 0, 0);
        for (int k = 0; k < 10; k++) step("restart_dwell", 1, 2'b00, 1, 2'b00, 0, 0);
        for (int k = 0; k < 2; k++) step("restart_blank1", 1, 2'b00, 1, 2'b00, 1, 0);
        for (int k = 0; k < 3; k++) step("restart_blank2", 1, 2'b00, 0, 2'b00, 1, 0);
        step("restart_commit", 1, 2'b00, 0, 2'b00, 0, 1);
        for (int k = 0; k < 3; k++) step("restart_after", 1, 2'b00, 0, 2'b00, 0, 0);

        // Auto-rotation: expected commit order queued up front, popped on each strobe.
        for (int k = 0; k < 2; k++) step("auto_rst", 0, 2'b00, 0, 2'b00, 0, 0);
        sb_mode.push_back(2'b01);
        sb_mode.push_back(2'b10);
        sb_mode.push_back(2'b00);
        sb_mode.push_back(2'b01);
        blank_run    = 0;
        first_strobe = -1;
        saw11        = 1'b0;
        for (int cyc = 1; cyc <= 80 && sb_mode.size() > 0; cyc++) begin
            tick(1, 2'b00, 1);
            if (mode == 2'b11) saw11 = 1'b1;
            if (mode_strobe) begin
                want = sb_mode.pop_front();
                check("auto_mode", int'(mode), int'(want));
                check("auto_blank_len", blank_run, BLK);
                if (first_strobe < 0) begin
                    first_strobe = cyc;
                    check("auto_first_commit_cycle", cyc, DWELL + 1 + BLK);
                end
            end
            blank_run = blank ? blank_run + 1 : 0;
        end
        check("auto_all_commits_seen", sb_mode.size(), 0);
        check("auto_never_11", int'(saw11), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
